// File: rtl/and_arbiter_ctrl.sv
// Two-requester arbiter in front of a shared clocked AND unit of latency LAT.
// Define AND_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default build uses fixed priority (requester 0 wins ties).
module and_arbiter_ctrl #(
    parameter int WIDTH = 8,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    input  logic [WIDTH-1:0] dp_y,
    output logic             busy,
    output logic             grant_id
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] state;
    logic [2:0] counter;
    logic       sel1;
    logic       can_accept;
    logic       accept;
    logic       rsp_taken;

`ifdef AND_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        sel1 = req1_valid && (!req0_valid || !last_grant);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= sel1;
        end
    end
`else
    always_comb begin
        sel1 = req1_valid && !req0_valid;
    end
`endif

    // Readies are forced low while reset is held, even though state already reads IDLE.
    always_comb begin
        can_accept = (state == ST_IDLE) && !reset;
        req1_ready = can_accept && sel1;
        req0_ready = can_accept && req0_valid && !sel1;
        accept     = req0_ready || req1_ready;
        rsp0_valid = (state == ST_RESP) && !grant_id;
        rsp1_valid = (state == ST_RESP) && grant_id;
        rsp_taken  = grant_id ? rsp1_ready : rsp0_ready;
        busy       = (state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            dp_a     <= '0;
            dp_b     <= '0;
            rsp_y    <= '0;
            counter  <= '0;
            grant_id <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dp_a     <= sel1 ? req1_a : req0_a;
                        dp_b     <= sel1 ? req1_b : req0_b;
                        grant_id <= sel1;
                        counter  <= 3'(LAT);
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // The extra cycle at zero lines the capture up with the unit's output.
                    if (counter == 3'd0) begin
                        rsp_y <= dp_y;
                        state <= ST_RESP;
                    end else begin
                        counter <= counter - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_taken) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_arbiter_ctrl.sv
// Scoreboard bench for and_arbiter_ctrl: predictor pushes expected results, monitor pops on responses.
// Builds with or without AND_ARB_ROUND_ROBIN_EN, matching the RTL build.
module tb_and_arbiter_ctrl;

    localparam int WIDTH = 8;
    localparam int LAT   = 3;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] y;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp_y, dp_a, dp_b, dp_y;
    logic             busy, grant_id;

    exp_t sb_q[$];
    bit   grant_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   model_idle = 1'b1;
    bit   model_last = 1'b1;
    bit   acc_now = 1'b0;
    bit   acc_id = 1'b0;
    bit   done_now = 1'b0;
    int   wait_cnt = 0;

    and_arbiter_ctrl #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y), .dp_a(dp_a), .dp_b(dp_b), .dp_y(dp_y),
        .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared AND unit: LAT register stages after the operand registers.
    logic [WIDTH-1:0] and_pipe [LAT];
    always @(posedge clk) begin
        and_pipe[0] <= dp_a & dp_b;
        for (int i = 1; i < LAT; i++) and_pipe[i] <= and_pipe[i-1];
    end
    assign dp_y = and_pipe[LAT-1];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input bit v0, input bit v1,
                                  input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                  input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                                  input bit r0, input bit r1);
        @(posedge clk);
        #1;
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        rsp0_ready = r0; rsp1_ready = r1;
    endtask

    // Predictor: decides who should be granted and what result that requester is owed.
    always @(negedge clk) begin
        bit exp_id;
        acc_now = 1'b0;
        if (reset) begin
            check_output("rst_ready", {req1_ready, req0_ready}, 2'b00);
            check_output("rst_busy", busy, 1'b0);
            check_output("rst_dp", {dp_a, dp_b}, '0);
            check_output("rst_rsp_y", rsp_y, '0);
            check_output("rst_grant", grant_id, 1'b0);
        end else if (model_idle) begin
            if (req0_valid && req1_valid) begin
`ifdef AND_ARB_ROUND_ROBIN_EN
                exp_id = !model_last;
`else
                exp_id = 1'b0;
`endif
            end else begin
                exp_id = req1_valid;
            end
            check_output("req_ready",
                         {req1_ready, req0_ready},
                         (req0_valid || req1_valid) ? (exp_id ? 2'b10 : 2'b01) : 2'b00);
            check_output("idle_busy", busy, 1'b0);
            if (req0_valid || req1_valid) begin
                sb_q.push_back('{id: exp_id, y: exp_id ? (req1_a & req1_b) : (req0_a & req0_b)});
                grant_log.push_back(exp_id);
                acc_now = 1'b1;
                acc_id  = exp_id;
            end
        end else begin
            check_output("busy_ready", {req1_ready, req0_ready}, 2'b00);
            check_output("busy_flag", busy, 1'b1);
        end
    end

    // Monitor: compares every presented response against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        done_now = 1'b0;
        if (reset) begin
            wait_cnt = 0;
            check_output("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
        end else if (rsp0_valid || rsp1_valid) begin
            wait_cnt = 0;
            if (sb_q.size() == 0) begin
                check_output("spurious_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
            end else begin
                e = sb_q[0];
                check_output("rsp_chan", {rsp1_valid, rsp0_valid}, e.id ? 2'b10 : 2'b01);
                check_output("rsp_y", rsp_y, e.y);
                check_output("rsp_grant", grant_id, e.id);
                if (e.id ? rsp1_ready : rsp0_ready) begin
                    void'(sb_q.pop_front());
                    done_now = 1'b1;
                end
            end
        end else if (sb_q.size() > 0) begin
            wait_cnt++;
            if (wait_cnt > LAT + 3) begin
                check_output("rsp_timeout", 1'b0, 1'b1);
                void'(sb_q.pop_front());
                done_now = 1'b1;
                wait_cnt = 0;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_idle <= 1'b1;
            model_last <= 1'b1;
        end else begin
            if (acc_now) begin
                model_idle <= 1'b0;
                model_last <= acc_id;
            end
            if (done_now) model_idle <= 1'b1;
        end
    end

    initial begin
        bit exp_seq [4];
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 0; rsp1_ready = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Both requesters continuously asking: observe the tie-break order.
        for (int i = 0; i < 4 * (LAT + 3) + 2; i++)
            apply_stimulus(1, 1, 8'hF0, 8'h3C, 8'hAA, 8'h0F, 1, 1);
`ifdef AND_ARB_ROUND_ROBIN_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        check_output("grant_count", grant_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check_output($sformatf("grant_seq%0d", i), grant_log[i], exp_seq[i]);

        repeat (LAT + 4) apply_stimulus(0, 0, '0, '0, '0, '0, 1, 1);

        // Requester 1 holds off taking its result while requester 0 waits and rsp0_ready is high.
        apply_stimulus(0, 1, '0, '0, 8'hAA, 8'hFF, 1, 0);
        for (int i = 0; i < LAT + 7; i++)
            apply_stimulus(1, 0, 8'h5A, 8'hC3, 8'h00, 8'h00, 1, 0);
        apply_stimulus(1, 0, 8'h5A, 8'hC3, 8'h00, 8'h00, 1, 1);
        repeat (LAT + 4) apply_stimulus(0, 0, '0, '0, '0, '0, 1, 1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            apply_stimulus($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                           WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        repeat (2 * LAT + 8) apply_stimulus(0, 0, '0, '0, '0, '0, 1, 1);

        // Reset while an operation is executing: it must vanish without a response.
        apply_stimulus(1, 0, 8'hFF, 8'h81, '0, '0, 1, 1);
        apply_stimulus(0, 0, '0, '0, '0, '0, 1, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (LAT + 6) apply_stimulus(0, 0, '0, '0, '0, '0, 1, 1);
        apply_stimulus(0, 1, '0, '0, 8'h3C, 8'h66, 1, 1);
        repeat (LAT + 6) apply_stimulus(0, 0, '0, '0, '0, '0, 1, 1);

        check_output("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
